// File: rtl/host_axil_master.sv
// Host-side AXI-lite initiator: one register read/write per command, response returned on rsp_*.
// Optional per-transaction timeout is built when HOST_AXIL_TIMEOUT_EN is defined.
module host_axil_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic        timeout_flag,
    output logic        host_awvalid,
    output logic [31:0] host_awaddr,
    input  logic        host_awready,
    output logic        host_wvalid,
    output logic [31:0] host_wdata,
    output logic [3:0]  host_wstrb,
    input  logic        host_wready,
    input  logic        host_bvalid,
    input  logic [1:0]  host_bresp,
    output logic        host_bready,
    output logic        host_arvalid,
    output logic [31:0] host_araddr,
    input  logic        host_arready,
    input  logic        host_rvalid,
    input  logic [31:0] host_rdata,
    input  logic [1:0]  host_rresp,
    output logic        host_rready
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, RESP} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_done, w_done;
    logic        expire;
    logic        tmo_fire;

    assign host_awaddr = addr_q;
    assign host_araddr = addr_q;
    assign host_wdata  = wdata_q;
    assign host_wstrb  = wstrb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A completing handshake always takes priority over the expiry.
    always_comb begin
        state_nxt    = state;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        host_awvalid = 1'b0;
        host_wvalid  = 1'b0;
        host_bready  = 1'b0;
        host_arvalid = 1'b0;
        host_rready  = 1'b0;
        tmo_fire     = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = cmd_write ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                host_awvalid = !aw_done;
                host_wvalid  = !w_done;
                if ((aw_done || host_awready) && (w_done || host_wready)) state_nxt = WR_RSP;
                else if (expire) begin
                    state_nxt = RESP;
                    tmo_fire  = 1'b1;
                end
            end
            WR_RSP: begin
                host_bready = 1'b1;
                if (host_bvalid) state_nxt = RESP;
                else if (expire) begin
                    state_nxt = RESP;
                    tmo_fire  = 1'b1;
                end
            end
            RD_REQ: begin
                host_arvalid = 1'b1;
                if (host_arready) state_nxt = RD_RSP;
                else if (expire) begin
                    state_nxt = RESP;
                    tmo_fire  = 1'b1;
                end
            end
            RD_RSP: begin
                host_rready = 1'b1;
                if (host_rvalid) state_nxt = RESP;
                else if (expire) begin
                    state_nxt = RESP;
                    tmo_fire  = 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (host_awvalid && host_awready) aw_done <= 1'b1;
            if (host_wvalid && host_wready)   w_done  <= 1'b1;
            if (host_bready && host_bvalid) begin
                rsp_rdata <= '0;
                rsp_resp  <= host_bresp;
            end
            if (host_rready && host_rvalid) begin
                rsp_rdata <= host_rdata;
                rsp_resp  <= host_rresp;
            end
            if (tmo_fire) begin
                rsp_rdata <= '0;
                rsp_resp  <= 2'b10;
            end
        end
    end

`ifdef HOST_AXIL_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;
    logic        busy;

    assign busy   = (state == WR_REQ) || (state == WR_RSP) || (state == RD_REQ) || (state == RD_RSP);
    assign expire = busy && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt      <= '0;
            rsp_timeout  <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid) tmo_cnt <= '0;
            else if (busy)                  tmo_cnt <= tmo_cnt + 16'd1;
            if ((host_bready && host_bvalid) || (host_rready && host_rvalid)) rsp_timeout <= 1'b0;
            if (tmo_fire) begin
                rsp_timeout  <= 1'b1;
                timeout_flag <= 1'b1;
            end
        end
    end
`else
    logic unused_tmo;

    assign unused_tmo   = |TIMEOUT_CYCLES;
    assign expire       = 1'b0;
    assign rsp_timeout  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_host_axil_master.sv
// Directed bench for host_axil_master; timeout scenarios run only when HOST_AXIL_TIMEOUT_EN is defined.
module tb_host_axil_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout, timeout_flag;
    logic        host_awvalid, host_awready, host_wvalid, host_wready;
    logic [31:0] host_awaddr, host_wdata, host_araddr, host_rdata;
    logic [3:0]  host_wstrb;
    logic        host_bvalid, host_bready, host_arvalid, host_arready, host_rvalid, host_rready;
    logic [1:0]  host_bresp, host_rresp;

    int total = 0;
    int bad   = 0;

    host_axil_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .timeout_flag(timeout_flag),
        .host_awvalid(host_awvalid), .host_awaddr(host_awaddr), .host_awready(host_awready),
        .host_wvalid(host_wvalid), .host_wdata(host_wdata), .host_wstrb(host_wstrb),
        .host_wready(host_wready), .host_bvalid(host_bvalid), .host_bresp(host_bresp),
        .host_bready(host_bready), .host_arvalid(host_arvalid), .host_araddr(host_araddr),
        .host_arready(host_arready), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .host_rresp(host_rresp), .host_rready(host_rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0; host_awready = 0; host_wready = 0; host_bvalid = 0; host_bresp = 0;
        host_arready = 0; host_rvalid = 0; host_rdata = 0; host_rresp = 0;
        tick(); tick();
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_awvalid", 32'(host_awvalid), 0);
        check("rst_arvalid", 32'(host_arvalid), 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_tflag", 32'(timeout_flag), 0);
        rst_n = 1'b1;
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 1);

        // zero-wait write
        host_awready = 1; host_wready = 1; host_bvalid = 1; host_bresp = 2'b00;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
        tick(); cmd_valid = 0;
        check("zw_awvalid", 32'(host_awvalid), 1);
        check("zw_wvalid", 32'(host_wvalid), 1);
        check("zw_awaddr", host_awaddr, 32'h10);
        check("zw_wdata", host_wdata, 32'hDEADBEEF);
        check("zw_wstrb", 32'(host_wstrb), 32'hF);
        tick();
        check("zw_bready", 32'(host_bready), 1);
        check("zw_awvalid_c2", 32'(host_awvalid), 0);
        check("zw_rsp_valid_c2", 32'(rsp_valid), 0);
        tick();
        check("zw_rsp_valid", 32'(rsp_valid), 1);
        check("zw_rsp_resp", 32'(rsp_resp), 0);
        check("zw_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1;
        tick(); rsp_ready = 0; host_bvalid = 0;
        check("zw_idle", 32'(cmd_ready), 1);

        // skewed write: W accepted in cycle 1, AW in cycle 4
        host_awready = 0; host_wready = 1;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h20; cmd_wdata = 32'h55AA00FF; cmd_wstrb = 4'h3;
        tick(); cmd_valid = 0;
        check("sk_wvalid_c1", 32'(host_wvalid), 1);
        check("sk_awvalid_c1", 32'(host_awvalid), 1);
        tick();
        check("sk_wvalid_c2", 32'(host_wvalid), 0);
        check("sk_awvalid_c2", 32'(host_awvalid), 1);
        check("sk_awaddr_c2", host_awaddr, 32'h20);
        tick();
        check("sk_awvalid_c3", 32'(host_awvalid), 1);
        check("sk_bready_c3", 32'(host_bready), 0);
        tick(); host_awready = 1;
        check("sk_awvalid_c4", 32'(host_awvalid), 1);
        check("sk_wvalid_c4", 32'(host_wvalid), 0);
        tick(); host_awready = 0; host_wready = 0;
        check("sk_bready_c5", 32'(host_bready), 1);
        check("sk_awvalid_c5", 32'(host_awvalid), 0);
        check("sk_wvalid_c5", 32'(host_wvalid), 0);
        host_bvalid = 1; host_bresp = 2'b00;
        tick(); host_bvalid = 0;
        check("sk_rsp_valid", 32'(rsp_valid), 1);
        rsp_ready = 1;
        tick(); rsp_ready = 0;

        // read with AR wait, R wait and SLVERR
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h40;
        tick(); cmd_valid = 0;
        check("rd_arvalid_c1", 32'(host_arvalid), 1);
        check("rd_araddr", host_araddr, 32'h40);
        check("rd_rready_c1", 32'(host_rready), 0);
        tick(); tick(); host_arready = 1;
        check("rd_arvalid_c3", 32'(host_arvalid), 1);
        tick(); host_arready = 0;
        check("rd_arvalid_c4", 32'(host_arvalid), 0);
        check("rd_rready_c4", 32'(host_rready), 1);
        tick(); tick();
        host_rvalid = 1; host_rdata = 32'h12345678; host_rresp = 2'b10;
        tick(); host_rvalid = 0; host_rdata = 32'hFFFFFFFF;
        check("rd_rsp_valid_c7", 32'(rsp_valid), 1);
        check("rd_rdata_c7", rsp_rdata, 32'h12345678);
        check("rd_resp_c7", 32'(rsp_resp), 2);
        check("rd_rready_c7", 32'(host_rready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rd_hold_valid", 32'(rsp_valid), 1);
            check("rd_hold_rdata", rsp_rdata, 32'h12345678);
            check("rd_hold_resp", 32'(rsp_resp), 2);
        end
        rsp_ready = 1;
        tick(); rsp_ready = 0;
        check("rd_done_valid", 32'(rsp_valid), 0);

`ifdef HOST_AXIL_TIMEOUT_EN
        // AR never accepted: expiry in cycle 8, RESP in cycle 9
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h44;
        tick(); cmd_valid = 0;
        for (int i = 0; i < 7; i++) tick();
        check("to_arvalid_c8", 32'(host_arvalid), 1);
        check("to_rsp_valid_c8", 32'(rsp_valid), 0);
        tick();
        check("to_arvalid_c9", 32'(host_arvalid), 0);
        check("to_rsp_valid", 32'(rsp_valid), 1);
        check("to_rsp_timeout", 32'(rsp_timeout), 1);
        check("to_resp", 32'(rsp_resp), 2);
        check("to_rdata", rsp_rdata, 0);
        check("to_flag", 32'(timeout_flag), 1);
        rsp_ready = 1;
        tick(); rsp_ready = 0;
        check("to_flag_sticky", 32'(timeout_flag), 1);

        // AR accepted exactly in the expiry cycle
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h48;
        tick(); cmd_valid = 0;
        for (int i = 0; i < 7; i++) tick();
        host_arready = 1;
        tick(); host_arready = 0;
        check("tw_rready", 32'(host_rready), 1);
        check("tw_rsp_valid_c9", 32'(rsp_valid), 0);
        host_rvalid = 1; host_rdata = 32'h0000A5A5; host_rresp = 2'b00;
        tick(); host_rvalid = 0;
        check("tw_rsp_valid", 32'(rsp_valid), 1);
        check("tw_rsp_timeout", 32'(rsp_timeout), 0);
        check("tw_rdata", rsp_rdata, 32'h0000A5A5);
        check("tw_resp", 32'(rsp_resp), 0);
        check("tw_flag", 32'(timeout_flag), 1);
        rsp_ready = 1;
        tick(); rsp_ready = 0;
`else
        check("nt_rsp_timeout", 32'(rsp_timeout), 0);
        check("nt_flag", 32'(timeout_flag), 0);
`endif

        // reset asserted while waiting in WR_RSP
        host_awready = 1; host_wready = 1; host_bvalid = 0;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h60; cmd_wdata = 32'h1; cmd_wstrb = 4'h1;
        tick(); cmd_valid = 0;
        tick();
        check("rm_bready", 32'(host_bready), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rm_async_bready", 32'(host_bready), 0);
        check("rm_async_awvalid", 32'(host_awvalid), 0);
        check("rm_async_wvalid", 32'(host_wvalid), 0);
        check("rm_async_rsp_valid", 32'(rsp_valid), 0);
        check("rm_async_flag", 32'(timeout_flag), 0);
        check("rm_async_awaddr", host_awaddr, 0);
        #1 rst_n = 1'b1;
        host_awready = 0; host_wready = 0;
        tick();
        check("rm_cmd_ready", 32'(cmd_ready), 1);

        // command held valid through RESP: next one accepted only after rsp handshake
        host_arready = 1; host_rvalid = 1; host_rdata = 32'h0BADF00D; host_rresp = 2'b00;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h80;
        tick(); cmd_addr = 32'h84;
        check("bp_cmd_ready_c1", 32'(cmd_ready), 0);
        tick();
        check("bp_cmd_ready_c2", 32'(cmd_ready), 0);
        tick();
        check("bp_rsp_valid_c3", 32'(rsp_valid), 1);
        check("bp_rdata_c3", rsp_rdata, 32'h0BADF00D);
        check("bp_cmd_ready_c3", 32'(cmd_ready), 0);
        tick();
        check("bp_cmd_ready_c4", 32'(cmd_ready), 0);
        check("bp_rsp_valid_c4", 32'(rsp_valid), 1);
        rsp_ready = 1;
        tick(); rsp_ready = 0;
        check("bp_cmd_ready_c5", 32'(cmd_ready), 1);
        check("bp_rsp_valid_c5", 32'(rsp_valid), 0);
        host_rdata = 32'hCAFE0001;
        tick(); cmd_valid = 0;
        check("bp_arvalid_2nd", 32'(host_arvalid), 1);
        check("bp_araddr_2nd", host_araddr, 32'h84);
        tick(); tick();
        check("bp_rdata_2nd", rsp_rdata, 32'hCAFE0001);
        rsp_ready = 1;
        tick(); rsp_ready = 0; host_arready = 0; host_rvalid = 0;
        check("bp_final_idle", 32'(cmd_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/host_axil_master.md
# host_axil_master

Host-side AXI-lite initiator that drives the GPU's host control port (`host_aw*`, `host_w*`, `host_b*`, `host_ar*`, `host_r*`). It takes single register read and write commands from the host command sequencer or testbench over a valid/ready command channel. It runs exactly one AXI-lite transaction at a time and returns the response data and status on a valid/ready response channel. It sits outside `gpu_top` on the host side and is the master end of the control interface.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: cycles allowed per transaction before it is aborted (legal range 2..65535).

Ports:
- Single clock `clk`; reset `rst_n`, asynchronous, active-low.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  32  byte address.
- `cmd_wdata`  in  32  write data.
- `cmd_wstrb`  in  4  write byte strobes.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  32  read data; 0 for writes.
- `rsp_resp`  out  2  AXI resp code (OKAY = 00, SLVERR = 10, ...).
- `rsp_timeout`  out  1  response produced by timeout.
- `timeout_flag`  out  1  sticky; set by any timeout, cleared only by reset.
- `host_awvalid`, `host_awaddr[31:0]`, `host_awready`(in): write address channel.
- `host_wvalid`, `host_wdata[31:0]`, `host_wstrb[3:0]`, `host_wready`(in): write data channel.
- `host_bvalid`(in), `host_bresp[1:0]`(in), `host_bready`: write response channel.
- `host_arvalid`, `host_araddr[31:0]`, `host_arready`(in): read address channel.
- `host_rvalid`(in), `host_rdata[31:0]`(in), `host_rresp[1:0]`(in), `host_rready`: read data channel.

## Operation
States: IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, RESP.

- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid`, latch addr, data, wstrb and direction, and clear the timeout counter.
  - Go to WR_REQ if `cmd_write`, else RD_REQ.
- **WR_REQ**
  - `host_awvalid` and `host_wvalid` assert together. Each channel deasserts independently after its own handshake, tracked by `aw_done` and `w_done`.
  - Go to WR_RSP once both are done. This includes the case where both handshakes happen in the same cycle.
- **WR_RSP**
  - `host_bready` = 1.
  - On `host_bvalid`, capture `host_bresp`, set rdata to 0, and go to RESP.
- **RD_REQ**
  - `host_arvalid` = 1.
  - On `host_arready`, go to RD_RSP.
- **RD_RSP**
  - `host_rready` = 1.
  - On `host_rvalid`, capture `host_rdata` and `host_rresp`, and go to RESP.
- **RESP**
  - `rsp_valid` = 1; all `rsp_*` outputs stay stable until `rsp_ready`.
  - On `rsp_ready`, go to IDLE.
- **Fixed rules**
  - AXI address, data and strobe outputs come from registers and stay stable while their valid is high.
  - A valid is never withdrawn before its handshake, except on timeout or reset.
  - `host_bready` and `host_rready` are 0 outside WR_RSP and RD_RSP.
- **Reset**
  - Asserting reset at any point, including mid-transaction, forces IDLE asynchronously.
  - All `host_*valid`, `host_*ready`, `rsp_valid`, `rsp_timeout` and `timeout_flag` go to 0.
  - `rsp_rdata`, `rsp_resp` and all address/data registers go to 0.
  - `cmd_ready` is 1 once reset is released.

## Timing
- Command handshake in cycle 0 → AXI request valid in cycle 1.
- With a zero-wait responder (ready high, response in the first cycle the master is ready), `rsp_valid` rises in cycle 3 for both reads and writes.
- Each responder wait cycle adds exactly one cycle.
- Back-to-back: the next command is accepted in the cycle after the `rsp_ready` handshake, so the minimum period is 4 cycles per transaction.
- Only one transaction is outstanding; `cmd_ready` = 0 outside IDLE.

## Configuration
- **`HOST_AXIL_TIMEOUT_EN` defined**
  - A 16-bit counter increments every cycle in WR_REQ, WR_RSP, RD_REQ and RD_RSP.
  - In a cycle where the counter equals `TIMEOUT_CYCLES-1` and the pending handshake does not complete:
    - drop all AXI valids and readies;
    - load `rsp_resp` = 10, `rsp_rdata` = 0, `rsp_timeout` = 1;
    - set `timeout_flag`;
    - go to RESP.
  - If the handshake completes in the expiry cycle, it wins and the transaction proceeds normally.
  - A late `bvalid` or `rvalid` after a timeout is ignored because the ready is low. Responder desynchronisation is a system error, flagged by `timeout_flag`.
- **Macro undefined**
  - No counter is built; the block waits indefinitely.
  - `rsp_timeout` and `timeout_flag` are tied to 0.

## Test plan
- **Zero-wait write.** Stimulus: write addr 0x10, data 0xDEADBEEF, wstrb 0xF; AW, W, B ready or valid immediately. Required: awaddr = 0x10 and wdata = 0xDEADBEEF in cycle 1; `rsp_valid` in cycle 3 with `rsp_resp` = 00 and `rsp_rdata` = 0.
- **Skewed write channels.** Stimulus: `host_wready` high in cycle 1, `host_awready` delayed to cycle 4. Required: `wvalid` drops after cycle 1; `awvalid` holds until cycle 4; `bready` rises in cycle 5; no second W beat.
- **Read with wait and error.** Stimulus: `arready` in cycle 3, `rvalid` in cycle 6 with rdata 0x12345678 and rresp 10. Required: `rsp_rdata` = 0x12345678 and `rsp_resp` = 10 in cycle 7; `rsp_ready` held low for 3 cycles keeps the outputs stable.
- **Timeout, macro defined.** Stimulus: `TIMEOUT_CYCLES` = 8; read with `arready` never asserted. Required: `arvalid` drops and `rsp_valid` rises with `rsp_timeout` = 1, `rsp_resp` = 10, `rdata` = 0; `timeout_flag` stays 1. Repeat with `arready` arriving in the expiry cycle → normal completion with `rsp_timeout` = 0.
- **Reset mid-op and backpressure.** Stimulus: assert `rst_n` = 0 during WR_RSP; after release, issue a command while `cmd_valid` is held through RESP. Required: all valids are 0 asynchronously; `cmd_ready` = 1 after release; the second command is accepted only in the cycle after the `rsp_ready` handshake.
